// File: rtl/ws2812b_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ws2812b_pkg
//  Description : Shared types and constants for the WS2812B line encoder.
//                Holds the encoder state encoding, the default bit timing
//                for a 64 MHz clock and the pixel width.
//  Revision    : 1.0  initial release
// ============================================================================
package ws2812b_pkg;

    // Pixel is {G[7:0], R[7:0], B[7:0]}, shifted out MSB first.
    localparam int PIXEL_W   = 24;
    localparam int BIT_IDX_W = $clog2(PIXEL_W);

    // Default timing at 64 MHz (15.625 ns per cycle).
    localparam int T0H_CYC_DEF  = 26;     // 0.40 us
    localparam int T1H_CYC_DEF  = 51;     // 0.80 us
    localparam int TBIT_CYC_DEF = 80;     // 1.25 us
    localparam int TRES_CYC_DEF = 5120;   // 80 us

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_LATCH = 2'd2
    } state_e;

    // Used to size the shared bit/latch cycle counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : ws2812b_pkg
`default_nettype wire

// File: rtl/ws2812b_bit_encoder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ws2812b_bit_encoder_if
//  Description : Pixel handshake between the register front-end (master)
//                and the WS2812B line encoder (slave).
//                  data_in : pixel {G,R,B}, sampled only on accept
//                  valid   : pixel offered
//                  latch   : append latch low period after this pixel
//                  ready   : encoder pending buffer is empty
//  Revision    : 1.0  initial release
// ============================================================================
interface ws2812b_bit_encoder_if;
    import ws2812b_pkg::*;

    logic [PIXEL_W-1:0] data_in;
    logic               valid;
    logic               latch;
    logic               ready;

    modport master (
        output data_in,
        output valid,
        output latch,
        input  ready
    );

    modport slave (
        input  data_in,
        input  valid,
        input  latch,
        output ready
    );

endinterface : ws2812b_bit_encoder_if
`default_nettype wire

// File: rtl/ws2812b_bit_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ws2812b_bit_encoder
//  Description : Serialises 24-bit GRB pixels onto a WS2812B data line using
//                NRZ pulse timing. A one-deep pending buffer lets a new pixel
//                be queued while the current one shifts, so consecutive
//                pixels go out with no gap. An optional per-pixel latch flag
//                appends the strip's reset/latch low period.
//  Ports       : clk    - clock (64 MHz nominal)
//                rst_n  - synchronous active-low reset
//                bus    - pixel handshake (slave side)
//                busy   - encoder active or pixel pending
//                led    - registered serial data to the strip
//  Revision    : 1.0  initial release
// ============================================================================
module ws2812b_bit_encoder
    import ws2812b_pkg::*;
#(
    parameter int T0H_CYC  = T0H_CYC_DEF,
    parameter int T1H_CYC  = T1H_CYC_DEF,
    parameter int TBIT_CYC = TBIT_CYC_DEF,
    parameter int TRES_CYC = TRES_CYC_DEF
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    ws2812b_bit_encoder_if.slave   bus,
    output logic                   busy,
    output logic                   led
);

    // One counter serves both the bit period and the latch period.
    localparam int CNT_W = $clog2(max_int(TBIT_CYC, TRES_CYC));

    localparam logic [CNT_W-1:0]     TBIT_LAST = CNT_W'(TBIT_CYC - 1);
    localparam logic [CNT_W-1:0]     TRES_LAST = CNT_W'(TRES_CYC - 1);
    localparam logic [CNT_W-1:0]     T0H_LEN   = CNT_W'(T0H_CYC);
    localparam logic [CNT_W-1:0]     T1H_LEN   = CNT_W'(T1H_CYC);
    localparam logic [BIT_IDX_W-1:0] BIT_FIRST = BIT_IDX_W'(PIXEL_W - 1);

    state_e               state_q,     state_d;
    logic [PIXEL_W-1:0]   sh_q,        sh_d;
    logic                 cur_latch_q, cur_latch_d;
    logic [BIT_IDX_W-1:0] bit_idx_q,   bit_idx_d;
    logic [CNT_W-1:0]     cyc_q,       cyc_d;
    logic                 pend_full_q, pend_full_d;
    logic [PIXEL_W-1:0]   pend_data_q, pend_data_d;
    logic                 pend_latch_q, pend_latch_d;
    logic                 led_q,       led_d;

    logic                 load;
    logic [CNT_W-1:0]     high_len;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sh_q         <= '0;
            cur_latch_q  <= 1'b0;
            bit_idx_q    <= '0;
            cyc_q        <= '0;
            pend_full_q  <= 1'b0;
            pend_data_q  <= '0;
            pend_latch_q <= 1'b0;
            led_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            cur_latch_q  <= cur_latch_d;
            bit_idx_q    <= bit_idx_d;
            cyc_q        <= cyc_d;
            pend_full_q  <= pend_full_d;
            pend_data_q  <= pend_data_d;
            pend_latch_q <= pend_latch_d;
            led_q        <= led_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        cur_latch_d  = cur_latch_q;
        bit_idx_d    = bit_idx_q;
        cyc_d        = cyc_q;
        pend_full_d  = pend_full_q;
        pend_data_d  = pend_data_q;
        pend_latch_d = pend_latch_q;
        load         = 1'b0;
        high_len     = T0H_LEN;
        led_d        = 1'b0;

        // Accept only into an empty buffer; a drain needs a full buffer, so
        // accept and drain can never land on the same edge.
        if (bus.valid && !pend_full_q) begin
            pend_data_d  = bus.data_in;
            pend_latch_d = bus.latch;
            pend_full_d  = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (pend_full_q) begin
                    load = 1'b1;
                end
            end

            ST_SEND: begin
                if (cyc_q == TBIT_LAST) begin
                    if (bit_idx_q != '0) begin
                        sh_d      = {sh_q[PIXEL_W-2:0], 1'b0};
                        bit_idx_d = bit_idx_q - BIT_IDX_W'(1);
                        cyc_d     = '0;
                    end else if (cur_latch_q) begin
                        state_d = ST_LATCH;
                        cyc_d   = '0;
                    end else if (pend_full_q) begin
                        load = 1'b1;   // gapless hand-over to the next pixel
                    end else begin
                        state_d = ST_IDLE;
                        cyc_d   = '0;
                    end
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end

            ST_LATCH: begin
                if (cyc_q == TRES_LAST) begin
                    if (pend_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cyc_d   = '0;
                    end
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cyc_d   = '0;
            end
        endcase

        if (load) begin
            sh_d        = pend_data_q;
            cur_latch_d = pend_latch_q;
            bit_idx_d   = BIT_FIRST;
            cyc_d       = '0;
            pend_full_d = 1'b0;
            state_d     = ST_SEND;
        end

        // led is registered, so its next value is derived from the next
        // counter/shift state; that keeps the high time aligned with cyc_q.
        high_len = sh_d[PIXEL_W-1] ? T1H_LEN : T0H_LEN;
        led_d    = (state_d == ST_SEND) && (cyc_d < high_len);
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.ready = !pend_full_q;
    assign busy      = (state_q != ST_IDLE) || pend_full_q;
    assign led       = led_q;

endmodule : ws2812b_bit_encoder
`default_nettype wire

// File: tb/tb_ws2812b_bit_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ws2812b_bit_encoder
//  Description : Self-checking bench for ws2812b_bit_encoder. One instance
//                uses the 64 MHz default timing, a second uses a short
//                override timing.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ws2812b_bit_encoder;
    import ws2812b_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ws2812b_bit_encoder_if bus_a ();
    ws2812b_bit_encoder_if bus_b ();
    logic busy_a, led_a, busy_b, led_b;

    ws2812b_bit_encoder dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave),
        .busy  (busy_a),
        .led   (led_a)
    );

    ws2812b_bit_encoder #(
        .T0H_CYC  (4),
        .T1H_CYC  (8),
        .TBIT_CYC (12),
        .TRES_CYC (40)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave),
        .busy  (busy_b),
        .led   (led_b)
    );

    int checks = 0;
    int errors = 0;
    int acc_a  = 0;

    always @(posedge clk) begin
        if (rst_n && bus_a.valid && bus_a.ready) acc_a <= acc_a + 1;
    end

    typedef struct {
        logic [23:0] data;
        logic        latch;
        int          ones;    // bits with the long high time
        int          total;   // summed high cycles over the pixel
        int          first;   // high width of G7
        int          last;    // high width of B0
    } vec_t;

    vec_t vecs [6];

    // capture results
    int c_n1, c_n0, c_tot, c_first, c_last, c_bad, c_lead;
    int d_n1, d_n0, d_tot, d_first, d_last, d_bad, d_lead;
    int k, acc0, seen_hi, ready_mid;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic led_of(input int sel);
        return (sel == 0) ? led_a : led_b;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? busy_a : busy_b;
    endfunction

    task automatic offer(input int sel, input logic [23:0] d, input logic l, input int hold);
        @(negedge clk);
        if (sel == 0) begin
            bus_a.data_in = d; bus_a.latch = l; bus_a.valid = 1'b1;
        end else begin
            bus_b.data_in = d; bus_b.latch = l; bus_b.valid = 1'b1;
        end
        repeat (hold) @(negedge clk);
        if (sel == 0) bus_a.valid = 1'b0;
        else          bus_b.valid = 1'b0;
    endtask

    // Measures the 24 high widths of one pixel, sampling on negedges.
    // bad counts bit periods not equal to tbit (or a missing pixel).
    task automatic capture(input int sel, input int t0h, input int t1h, input int tbit,
                           output int n1, output int n0, output int tot,
                           output int first, output int last,
                           output int bad, output int lead);
        int h, l;
        n1 = 0; n0 = 0; tot = 0; first = 0; last = 0; bad = 0; lead = 0;
        while (!led_of(sel) && lead < 300) begin
            lead++;
            @(negedge clk);
        end
        if (!led_of(sel)) begin
            bad = 1000;
            return;
        end
        for (int b = 0; b < 24; b++) begin
            h = 0;
            while (led_of(sel) && h <= tbit) begin
                h++;
                @(negedge clk);
            end
            l = 0;
            while (!led_of(sel) && l < tbit - h) begin
                l++;
                @(negedge clk);
            end
            if (h + l != tbit) bad++;
            if (h == t1h)      n1++;
            else if (h == t0h) n0++;
            tot += h;
            if (b == 0)  first = h;
            if (b == 23) last  = h;
        end
    endtask

    // Cycles spent busy with led low, starting at the current sample.
    task automatic low_busy_len(input int sel, input int lim, output int n);
        n = 0;
        while (busy_of(sel) && !led_of(sel) && n < lim) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_pixel(input string tag, input int exp_n1, input int exp_tot,
                               input int exp_first, input int exp_last);
        check({tag, "_period_errs"}, c_bad, 0);
        check({tag, "_long_bits"},   c_n1, exp_n1);
        check({tag, "_short_bits"},  c_n0, 24 - exp_n1);
        check({tag, "_high_total"},  c_tot, exp_tot);
        check({tag, "_first_w"},     c_first, exp_first);
        check({tag, "_last_w"},      c_last, exp_last);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{24'hFF0000, 1'b1,  8,  824, 51, 26};
        vecs[1] = '{24'h000001, 1'b0,  1,  649, 26, 51};
        vecs[2] = '{24'h123456, 1'b0,  9,  849, 26, 26};
        vecs[3] = '{24'hFFFFFF, 1'b0, 24, 1224, 51, 51};
        vecs[4] = '{24'h000000, 1'b1,  0,  624, 26, 26};
        vecs[5] = '{24'h800001, 1'b0,  2,  674, 51, 51};

        bus_a.valid = 1'b0; bus_a.latch = 1'b0; bus_a.data_in = '0;
        bus_b.valid = 1'b0; bus_b.latch = 1'b0; bus_b.data_in = '0;

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_led",   led_a, 0);
        check("rst_ready", bus_a.ready, 1);
        check("rst_busy",  busy_a, 0);
        check("rst_b_led", led_b, 0);
        check("rst_b_ready", bus_b.ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- first pixel: handshake latency ----------------
        offer(0, 24'hFF0000, 1'b1, 1);
        check("accept_ready_low", bus_a.ready, 0);
        check("accept_busy",      busy_a, 1);
        check("accept_led_low",   led_a, 0);
        capture(0, 26, 51, 80, c_n1, c_n0, c_tot, c_first, c_last, c_bad, c_lead);
        check("first_rise_lead", c_lead, 1);
        check_pixel("px_ff0000", 8, 824, 51, 26);
        low_busy_len(0, 6000, k);
        check("latch_len", k, 5120);
        check("latch_done_busy",  busy_a, 0);
        check("latch_done_ready", bus_a.ready, 1);

        // ---------------- table-driven pixels ----------------
        for (int i = 0; i < 6; i++) begin
            offer(0, vecs[i].data, vecs[i].latch, 1);
            capture(0, 26, 51, 80, c_n1, c_n0, c_tot, c_first, c_last, c_bad, c_lead);
            check_pixel($sformatf("vec%0d", i), vecs[i].ones, vecs[i].total,
                        vecs[i].first, vecs[i].last);
            low_busy_len(0, 6000, k);
            check($sformatf("vec%0d_tail", i), k, vecs[i].latch ? 5120 : 0);
            check($sformatf("vec%0d_idle", i), busy_a, 0);
        end

        // ---------------- back-to-back, valid held 4 cycles on the second ----
        acc0 = acc_a;
        offer(0, 24'hAAAAAA, 1'b0, 1);
        fork
            capture(0, 26, 51, 80, c_n1, c_n0, c_tot, c_first, c_last, c_bad, c_lead);
            begin
                repeat (200) @(negedge clk);
                bus_a.data_in = 24'h555555; bus_a.latch = 1'b1; bus_a.valid = 1'b1;
                repeat (4) @(negedge clk);
                bus_a.valid = 1'b0;
            end
        join
        check_pixel("b2b_aa", 12, 924, 51, 26);
        capture(0, 26, 51, 80, d_n1, d_n0, d_tot, d_first, d_last, d_bad, d_lead);
        check("b2b_gap", d_lead, 0);
        c_n1 = d_n1; c_n0 = d_n0; c_tot = d_tot; c_first = d_first; c_last = d_last; c_bad = d_bad;
        check_pixel("b2b_55", 12, 924, 26, 51);
        check("b2b_accepts", acc_a - acc0, 2);
        low_busy_len(0, 6000, k);
        check("b2b_latch_len", k, 5120);
        seen_hi = 0;
        repeat (240) begin
            @(negedge clk);
            if (led_a) seen_hi++;
        end
        check("b2b_no_extra_pixel", seen_hi, 0);

        // ---------------- reset mid-pixel ----------------
        offer(0, 24'hFFFFFF, 1'b0, 1);
        k = 0;
        while (!led_a && k < 300) begin
            k++;
            @(negedge clk);
        end
        check("mid_rst_started", led_a, 1);
        repeat (10 * 80 + 5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_led",   led_a, 0);
        check("mid_rst_ready", bus_a.ready, 1);
        check("mid_rst_busy",  busy_a, 0);
        rst_n = 1'b1;
        offer(0, 24'h000001, 1'b0, 1);
        capture(0, 26, 51, 80, c_n1, c_n0, c_tot, c_first, c_last, c_bad, c_lead);
        check_pixel("post_rst", 1, 649, 26, 51);

        // ---------------- pending pixel arrives during LATCH ----------------
        offer(0, 24'hF00000, 1'b1, 1);
        capture(0, 26, 51, 80, c_n1, c_n0, c_tot, c_first, c_last, c_bad, c_lead);
        check_pixel("lp_a", 4, 724, 51, 26);
        k = 0;
        ready_mid = 1;
        while (!led_a && k < 6000) begin
            if (k == 100) begin
                bus_a.data_in = 24'h00000F; bus_a.latch = 1'b0; bus_a.valid = 1'b1;
            end
            if (k == 101) begin
                bus_a.valid = 1'b0;
                ready_mid = bus_a.ready;
            end
            k++;
            @(negedge clk);
        end
        check("lp_ready_during_latch", ready_mid, 0);
        check("lp_latch_before_b", k, 5120);
        capture(0, 26, 51, 80, c_n1, c_n0, c_tot, c_first, c_last, c_bad, c_lead);
        check_pixel("lp_b", 4, 724, 26, 51);
        check("lp_idle", busy_a, 0);

        // ---------------- short-timing instance ----------------
        offer(1, 24'h800001, 1'b1, 1);
        capture(1, 4, 8, 12, c_n1, c_n0, c_tot, c_first, c_last, c_bad, c_lead);
        check("ovr_period_errs", c_bad, 0);
        check("ovr_long_bits",   c_n1, 2);
        check("ovr_short_bits",  c_n0, 22);
        check("ovr_high_total",  c_tot, 104);
        check("ovr_first_w",     c_first, 8);
        check("ovr_last_w",      c_last, 8);
        low_busy_len(1, 200, k);
        check("ovr_latch_len", k, 40);
        check("ovr_idle", busy_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ws2812b_bit_encoder
`default_nettype wire
